// File: rtl/keccak_round_ctrl.sv
// Keccak-f[1600] round sequencer: load handshake, round counter,
// per-cycle round enables and a held valid/ready result handshake.
module keccak_round_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int UNROLL     = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       abort_i,
  output logic       state_load_o,
  output logic       round_en_o,
  output logic [4:0] round_number_o,
  output logic       round_last_o,
  output logic       busy_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 24 || UNROLL < 1 ||
      (NUM_ROUNDS % UNROLL) != 0) begin : g_bad_cfg
    $error("keccak_round_ctrl: bad NUM_ROUNDS/UNROLL");
  end

  localparam logic [4:0] STEP = 5'(UNROLL);
  localparam logic [4:0] LAST = 5'(NUM_ROUNDS - UNROLL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       cnt_last;

  assign cnt_last = (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // abort wins over every other transition, including load and drain
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            state_d = ROUND;
            cnt_d   = '0;
          end
        end
        ROUND: begin
          if (cnt_last) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + STEP;
          end
        end
        DONE: begin
          if (out_ready_i) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready_o     = 1'b0;
    state_load_o   = 1'b0;
    round_en_o     = 1'b0;
    round_number_o = '0;
    round_last_o   = 1'b0;
    busy_o         = 1'b0;
    out_valid_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_o   = 1'b1;
        state_load_o = in_valid_i & ~abort_i;
      end
      ROUND: begin
        round_en_o     = 1'b1;
        round_number_o = cnt_q;
        round_last_o   = cnt_last;
        busy_o         = 1'b1;
      end
      DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Randomized + directed bench for keccak_round_ctrl, UNROLL=1 and UNROLL=4
// instances checked every cycle against a round-position reference model.
module tb_keccak_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] iv, ab, ordy;
  logic [1:0] in_rdy, load, en, last, busy, ov;
  logic [4:0] rn0, rn1;

  keccak_round_ctrl #(.NUM_ROUNDS(24), .UNROLL(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(iv[0]), .in_ready_o(in_rdy[0]),
    .abort_i(ab[0]), .state_load_o(load[0]),
    .round_en_o(en[0]), .round_number_o(rn0),
    .round_last_o(last[0]), .busy_o(busy[0]),
    .out_valid_o(ov[0]), .out_ready_i(ordy[0])
  );

  keccak_round_ctrl #(.NUM_ROUNDS(24), .UNROLL(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(iv[1]), .in_ready_o(in_rdy[1]),
    .abort_i(ab[1]), .state_load_o(load[1]),
    .round_en_o(en[1]), .round_number_o(rn1),
    .round_last_o(last[1]), .busy_o(busy[1]),
    .out_valid_o(ov[1]), .out_ready_i(ordy[1])
  );

  int total = 0;
  int bad   = 0;
  // -1: idle, 0..steps-1: k-th round cycle, steps: result held
  int pos[2];

  task automatic check_eq(string tag, logic [63:0] got,
                          logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unr(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int steps(int i);
    return 24 / unr(i);
  endfunction

  // FIPS 202 rc(t) via the degree-8 LFSR
  function automatic logic rc_bit(int t);
    logic [8:0] r;
    r = 9'h001;
    for (int k = 1; k <= t % 255; k++) begin
      r = r << 1;
      if (r[8]) r = r ^ 9'h171;
    end
    return r[0];
  endfunction

  function automatic logic [63:0] rc_of(int ir);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < 7; j++)
      if (rc_bit(j + 7 * ir)) v[(1 << j) - 1] = 1'b1;
    return v;
  endfunction

  // {in_ready, load, en, rn[4:0], last, busy, out_valid}
  function automatic logic [10:0] exp_vec(int i);
    int p;
    logic [4:0] n;
    p = pos[i];
    n = '0;
    if (p < 0)
      return {1'b1, iv[i] & ~ab[i], 1'b0, 5'd0, 3'b000};
    if (p < steps(i)) begin
      n = 5'(p * unr(i));
      return {2'b00, 1'b1, n, p == steps(i) - 1, 2'b10};
    end
    return {3'b000, 5'd0, 3'b011};
  endfunction

  function automatic logic [10:0] obs_vec(int i);
    if (i == 0)
      return {in_rdy[0], load[0], en[0], rn0, last[0], busy[0], ov[0]};
    return {in_rdy[1], load[1], en[1], rn1, last[1], busy[1], ov[1]};
  endfunction

  function automatic int next_pos(int i);
    int p;
    p = pos[i];
    if (!rst_n || ab[i]) return -1;
    if (p < 0) return iv[i] ? 0 : -1;
    if (p < steps(i)) return p + 1;
    return ordy[i] ? -1 : p;
  endfunction

  // inputs are driven at the negedge; outputs checked 1ns later
  task automatic tick();
    int np[2];
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d_outs", unr(i)), 64'(obs_vec(i)),
               64'(exp_vec(i)));
      np[i] = next_pos(i);
    end
    if (pos[0] >= 0 && pos[0] < steps(0))
      check_eq("u1_rc", rc_of(int'(rn0)), rc_of(pos[0]));
    @(posedge clk);
    pos[0] = np[0];
    pos[1] = np[1];
    @(negedge clk);
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    iv = '0; ab = '0; ordy = '0;
    pos[0] = -1; pos[1] = -1;
    @(negedge clk);
    ticks(3);
    rst_n = 1'b1;

    // single load, latency and round indices
    ordy = 2'b11;
    iv = 2'b11; tick();
    iv = 2'b00; ticks(30);

    // back-pressure with in_valid held high
    ordy = 2'b00;
    iv = 2'b11; tick();
    for (int k = 0; k < 30 && pos[0] != steps(0); k++) tick();
    ticks(5);
    ordy = 2'b11; tick();
    ordy = 2'b00; ticks(3);
    ab = 2'b11; tick();
    ab = 2'b00; iv = 2'b00; ticks(2);

    // abort at round 10, then a clean restart
    ordy = 2'b11;
    iv = 2'b11; tick();
    iv = 2'b00;
    for (int k = 0; k < 30 && pos[0] != 10; k++) tick();
    ab = 2'b11; tick();
    ab = 2'b00; ticks(3);
    iv = 2'b11; tick();
    iv = 2'b00; ticks(28);

    // async reset asserted between edges during round 7
    iv = 2'b11; tick();
    iv = 2'b00;
    for (int k = 0; k < 30 && pos[0] != 7; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    pos[0] = -1; pos[1] = -1;
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("u%0d_arst", unr(i)), 64'(obs_vec(i)),
               64'(exp_vec(i)));
    @(negedge clk);
    rst_n = 1'b1;
    iv = 2'b11; tick();
    iv = 2'b00; ticks(30);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        iv[i]   = 1'($urandom_range(0, 1));
        ordy[i] = 1'($urandom_range(0, 2) != 0);
        ab[i]   = 1'($urandom_range(0, 40) == 0);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
